// File: rtl/onehot_decoder_stream.sv
// Registered binary-to-one-hot decoder on a valid/ready stream.
// A main/skid register pair gives full throughput with a flop-driven I_ready.
module onehot_decoder_stream #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [IW-1:0] I,
    input  logic          I_valid,
    output logic          I_ready,
    output logic [N-1:0]  O,
    output logic          O_err,
    output logic          O_valid,
    input  logic          O_ready,
    output logic          ERR,
    input  logic          CLEAR
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t state, state_n;

    logic         ready_q;
    logic         err_q;
    logic [N-1:0] main_o, skid_o;
    logic         main_err, skid_err;

    logic [N-1:0] dec;
    logic         dec_err;
    logic         acc;
    logic         ld_main_in, ld_main_skid, ld_skid, drain;

    // An index with no matching output bit is exactly the out-of-range case.
    always_comb begin
        dec = '0;
        for (int k = 0; k < N; k++) begin
            if (I == IW'(k)) dec[k] = 1'b1;
        end
        dec_err = ~|dec;
    end

    assign acc = I_valid & ready_q;

    always_comb begin
        state_n      = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        drain        = 1'b0;
        unique case (state)
            EMPTY: begin
                if (acc) begin
                    state_n    = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && O_ready) begin
                    ld_main_in = 1'b1;
                end else if (acc) begin
                    state_n = FULL;
                    ld_skid = 1'b1;
                end else if (O_ready) begin
                    state_n = EMPTY;
                    drain   = 1'b1;
                end
            end
            FULL: begin
                if (O_ready) begin
                    state_n      = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            ready_q <= (state_n != FULL);
        end
    end

    // Main is zeroed on drain so O reads all zeros while O_valid is low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_o   <= '0;
            main_err <= 1'b0;
            skid_o   <= '0;
            skid_err <= 1'b0;
        end else begin
            if (ld_main_in) begin
                main_o   <= dec;
                main_err <= dec_err;
            end else if (ld_main_skid) begin
                main_o   <= skid_o;
                main_err <= skid_err;
            end else if (drain) begin
                main_o   <= '0;
                main_err <= 1'b0;
            end
            if (ld_skid) begin
                skid_o   <= dec;
                skid_err <= dec_err;
            end else if (ld_main_skid) begin
                skid_o   <= '0;
                skid_err <= 1'b0;
            end
        end
    end

    // Setting takes priority over CLEAR in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else if (acc && dec_err) begin
            err_q <= 1'b1;
        end else if (CLEAR) begin
            err_q <= 1'b0;
        end
    end

    assign I_ready = ready_q;
    assign O       = main_o;
    assign O_err   = main_err;
    assign O_valid = (state != EMPTY);
    assign ERR     = err_q;

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed bench for onehot_decoder_stream: N=4 vector table plus
// N=5 out-of-range sequences.
module tb_onehot_decoder_stream;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // N=4 instance
    logic       rst4, iv4, ordy4, clr4;
    logic [1:0] i4;
    logic       ir4, oerr4, ov4, err4;
    logic [3:0] o4;

    onehot_decoder_stream #(.N(4), .IW(2)) u4 (
        .CLK(CLK), .RESET(rst4), .I(i4), .I_valid(iv4), .I_ready(ir4),
        .O(o4), .O_err(oerr4), .O_valid(ov4), .O_ready(ordy4),
        .ERR(err4), .CLEAR(clr4)
    );

    // N=5 instance
    logic       rst5, iv5, ordy5, clr5;
    logic [2:0] i5;
    logic       ir5, oerr5, ov5, err5;
    logic [4:0] o5;

    onehot_decoder_stream #(.N(5), .IW(3)) u5 (
        .CLK(CLK), .RESET(rst5), .I(i5), .I_valid(iv5), .I_ready(ir5),
        .O(o5), .O_err(oerr5), .O_valid(ov5), .O_ready(ordy5),
        .ERR(err5), .CLEAR(clr5)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] i;
        logic       iv;
        logic       ordy;
        logic       clr;
        logic [3:0] o;
        logic       oerr;
        logic       ov;
        logic       ir;
        logic       err;
    } vec_t;

    vec_t tbl [20];

    // Drive N=5 inputs for one edge, then check state after that edge.
    task automatic step5(input string tag, input logic rst, input logic [2:0] i,
                         input logic iv, input logic ordy, input logic clr,
                         input logic [4:0] eo, input logic eoerr,
                         input logic eov, input logic eir, input logic eerr);
        rst5 = rst; i5 = i; iv5 = iv; ordy5 = ordy; clr5 = clr;
        @(posedge CLK);
        #1;
        check({tag, " O"}, 32'(o5), 32'(eo));
        check({tag, " O_err"}, 32'(oerr5), 32'(eoerr));
        check({tag, " O_valid"}, 32'(ov5), 32'(eov));
        check({tag, " I_ready"}, 32'(ir5), 32'(eir));
        check({tag, " ERR"}, 32'(err5), 32'(eerr));
        @(negedge CLK);
    endtask

    initial begin
        //          rst   i     iv    ordy  clr   O        oerr  ov    ir    err
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0};

        rst4 = 1'b1; i4 = '0; iv4 = 1'b0; ordy4 = 1'b0; clr4 = 1'b0;
        rst5 = 1'b1; i5 = '0; iv5 = 1'b0; ordy5 = 1'b0; clr5 = 1'b0;
        @(negedge CLK);

        for (int n = 0; n < 20; n++) begin
            rst4 = tbl[n].rst; i4 = tbl[n].i; iv4 = tbl[n].iv;
            ordy4 = tbl[n].ordy; clr4 = tbl[n].clr;
            @(posedge CLK);
            #1;
            check($sformatf("v%0d O", n), 32'(o4), 32'(tbl[n].o));
            check($sformatf("v%0d O_err", n), 32'(oerr4), 32'(tbl[n].oerr));
            check($sformatf("v%0d O_valid", n), 32'(ov4), 32'(tbl[n].ov));
            check($sformatf("v%0d I_ready", n), 32'(ir4), 32'(tbl[n].ir));
            check($sformatf("v%0d ERR", n), 32'(err4), 32'(tbl[n].err));
            check($sformatf("v%0d onehot0", n), 32'($onehot0(o4)), 32'd1);
            @(negedge CLK);
        end

        //     tag    rst   i     iv    ordy  clr   O         oerr  ov    ir    err
        step5("r0",  1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        step5("r1",  1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        step5("i6",  1'b0, 3'd6, 1'b1, 1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b1);
        step5("dr",  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1);
        step5("idl", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1);
        step5("clr", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        step5("i4",  1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 5'b10000, 1'b0, 1'b1, 1'b1, 1'b0);
        step5("i7c", 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b1);
        step5("dr2", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1);
        step5("i5s", 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b1);
        step5("i1s", 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
        step5("mv",  1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'b00010, 1'b0, 1'b1, 1'b1, 1'b0);
        step5("dr3", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_stream.md
Name: onehot_decoder_stream

Overview:
- Registered binary-to-one-hot decoder, the inverse of the team's one-hot-to-binary encoder.
- Accepts a stream of binary indices over a valid/ready handshake and emits the N-wide one-hot code one cycle later.
- A 2-entry skid buffer gives full throughput while keeping I_ready a pure register-derived signal.
- Sits between index-producing control logic (arbiters, encoders) and select/enable fan-out.

Parameters:
- N, 4, number of one-hot outputs; N >= 2, need not be a power of two.
- IW, 2, index width; must equal ceil(log2(N)).

Ports:
- CLK  input  1  clock, rising-edge.
- RESET  input  1  synchronous, active-high reset.
- I  input  IW  binary index.
- I_valid  input  1  index valid.
- I_ready  output  1  block can accept an index this cycle.
- O  output  N  one-hot code; bit k = 1 iff the decoded index equals k.
- O_err  output  1  current output beat carried an out-of-range index (I >= N).
- O_valid  output  1  O/O_err valid.
- O_ready  input  1  downstream accepts.
- ERR  output  1  sticky out-of-range flag.
- CLEAR  input  1  clears ERR.

Behaviour:
- Reset (RESET high at a CLK edge):
  - O=0, O_err=0, O_valid=0, ERR=0, I_ready=1 after the edge.
  - Both buffer entries are invalidated; any in-flight beats are dropped.
  - RESET overrides all other inputs in the same cycle.
- Handshake:
  - A beat transfers on an input when valid&ready are both high at the edge.
  - O_valid, once high, holds O and O_err stable until O_ready is sampled high.
  - I_valid may fall without a transfer; the block never depends on I_valid staying high.
- Decode:
  - For I < N, O = 1 << I and O_err = 0.
  - For I >= N, which is only possible when N is not a power of two, O is all zeros and O_err = 1.
- Storage: a main register drives O/O_valid; a skid register is used only when the main register is stalled.
  - EMPTY (main invalid, skid invalid): I_ready=1. Accept -> ONE. Decoded value appears on O the next cycle, so latency is 1.
  - ONE (main valid, skid invalid): I_ready=1.
    - Accept and O_ready -> stay ONE; main loads the new beat.
    - Accept and !O_ready -> FULL; the new beat goes to skid.
    - No accept and O_ready -> EMPTY.
  - FULL (both valid): I_ready=0.
    - O_ready -> ONE; skid moves to main.
    - !O_ready -> hold.
- I_ready = NOT skid_valid. It comes directly from a flop, with no combinational path from O_ready.
- Ordering is strictly FIFO; no beat is duplicated or dropped.
- Sustained throughput is 1 beat/cycle when O_ready stays high.
- ERR:
  - Set at the edge where an out-of-range index is accepted on the input.
  - CLEAR high clears it at the edge.
  - If set and CLEAR occur in the same cycle, set wins and ERR = 1.
- Invariant: O has at most one bit set. O is all zeros whenever O_valid=0 or O_err=1.

Test Plan:
- Reset then idle:
  - Assert RESET 2 cycles.
  - Required: O=0, O_valid=0, ERR=0, I_ready=1.
- Single beat, N=4:
  - I=2 with I_valid for 1 cycle, O_ready=1.
  - Required: next cycle O=4'b0100, O_valid=1, O_err=0; the following cycle O_valid=0.
- Streaming:
  - I=0,1,2,3 on back-to-back cycles, O_ready=1.
  - Required: O=0001,0010,0100,1000 on consecutive cycles with no bubbles; I_ready stays 1.
- Backpressure:
  - O_ready=0, send I=1 then I=3.
  - Required: O holds 0010; I_ready drops to 0 after the second accept; a third I_valid is not accepted.
  - Raise O_ready: O shows 0010, then 1000, then O_valid=0.
- Out of range, N=5, IW=3:
  - Send I=6.
  - Required: O=5'b00000, O_err=1, O_valid=1; ERR=1 and stays 1.
  - CLEAR for 1 cycle -> ERR=0.
  - Send I=7 with CLEAR high in the same cycle -> ERR stays 1.
- Reset mid-operation:
  - Reach FULL with O_ready=0, then pulse RESET.
  - Required: O_valid=0 and I_ready=1 after the edge; no stale beat ever emerges once O_ready rises.
